// File: rtl/aes_pkg.sv
// Shared cipher-controller package.
//   BLOCK_W / WORD_W / NWORDS : result block width, output word width and
//                               words per block for the out-buffer path.
//   ob_state_e                : out-buffer serializer states.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int NWORDS  = BLOCK_W / WORD_W;

    // IDLE: nothing buffered, out_valid low.
    // SEND: at least one block held, its current word is on out_data.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ob_state_e;

endpackage

// File: rtl/cipher_blk_fifo.sv
// Block storage for cipher_out_buf: DEPTH slots of BLOCK_W bits plus the
// write/read pointers. It keeps no occupancy count; the owner decides when
// a write or pop is legal.
// Ports:
//   clk, nrst  clock, async active-low reset (pointers only)
//   clr        synchronous clear of both pointers; beats wr_en and pop
//   wr_en      write wr_data into the slot at wr_ptr and advance wr_ptr
//   wr_data    block to store
//   pop        advance rd_ptr past the oldest block
//   rd_data    oldest block (slot at rd_ptr), combinational
module cipher_blk_fifo #(
    parameter int BLOCK_W = 128,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic               pop,
    output logic [BLOCK_W-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Storage is deliberately not reset; stale contents are never visible
    // because the owner only reads slots it has written since the last clear.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cipher_out_buf.sv
// Output buffer of the cipher controller. Captures the core result on each
// done pulse into a small block FIFO and serializes every block onto a
// valid/ready word stream, most-significant word first.
// Ports:
//   clk, nrst   clock, async active-low reset
//   clr         synchronous clear (empties buffer, clears overflow)
//   done        one-cycle capture strobe, result valid in the same cycle
//   result      BLOCK_W-bit block to capture
//   out_data    current word (0 when out_valid is low)
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word this cycle
//   out_last    current word is the last of its block
//   full        all DEPTH slots occupied
//   overflow    sticky: a done was dropped for lack of space
//   count       blocks held, including one partially sent
module cipher_out_buf #(
    parameter int BLOCK_W = aes_pkg::BLOCK_W,
    parameter int WORD_W  = aes_pkg::WORD_W,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clr,
    input  logic                       done,
    input  logic [BLOCK_W-1:0]         result,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import aes_pkg::*;

    localparam int NW = BLOCK_W / WORD_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    ob_state_e          state;
    ob_state_e          state_nx;
    logic [IW-1:0]      widx;
    logic [CW-1:0]      count_nx;
    logic [BLOCK_W-1:0] blk;
    logic               last_word;
    logic               xfer;
    logic               pop;
    logic               accept;

    cipher_blk_fifo #(
        .BLOCK_W (BLOCK_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (clr),
        .wr_en   (accept),
        .wr_data (result),
        .pop     (pop),
        .rd_data (blk)
    );

    always_comb begin
        out_valid = (state == SEND);
        last_word = (widx == LAST_IDX);
        xfer      = out_valid && out_ready;
        pop       = xfer && last_word && !clr;
        // A pop in the same cycle frees a slot, so a full buffer still
        // takes the new block on the final-word handshake.
        accept    = done && !clr && ((count != DEPTH_C) || pop);
    end

    always_comb begin
        count_nx = count;
        case ({accept, pop})
            2'b10:   count_nx = count + ONE_C;
            2'b01:   count_nx = count - ONE_C;
            default: count_nx = count;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = SEND;
                SEND:    if (pop && !accept && count == ONE_C) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            widx     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            widx     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (xfer) begin
                widx <= last_word ? '0 : widx + IW'(1);
            end
            if (done && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // Word 0 sits in the top WORD_W bits of the block.
    always_comb begin
        out_last = out_valid && last_word;
        out_data = '0;
        if (out_valid) begin
            out_data = blk[BLOCK_W - 1 - int'(widx) * WORD_W -: WORD_W];
        end
    end

    assign full = (count == DEPTH_C);

endmodule

// File: tb/tb_cipher_out_buf.sv
module tb_cipher_out_buf;

    logic         clk = 1'b0;
    logic         nrst;
    logic         clr;
    logic         done;
    logic [127:0] result;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         full;
    logic         overflow;
    logic [1:0]   count;

    cipher_out_buf #(.BLOCK_W(128), .WORD_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (clr),
        .done      (done),
        .result    (result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        logic [31:0]  w [4];
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    vec_t vecs [3];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    bit   pat_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one done pulse; push the expected words only if capture is expected.
    task automatic send(input logic [127:0] b, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input bit acc);
        exp_t e;
        done   = 1'b1;
        result = b;
        if (acc) begin
            e.d = w0; e.last = 1'b0; sb.push_back(e);
            e.d = w1; e.last = 1'b0; sb.push_back(e);
            e.d = w2; e.last = 1'b0; sb.push_back(e);
            e.d = w3; e.last = 1'b1; sb.push_back(e);
        end
        tick();
        done = 1'b0;
    endtask

    task automatic send_vec(input int i, input bit acc);
        send(vecs[i].blk, vecs[i].w[0], vecs[i].w[1], vecs[i].w[2], vecs[i].w[3], acc);
    endtask

    task automatic send_rep(input logic [31:0] v, input bit acc);
        send({4{v}}, v, v, v, v, acc);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!out_valid && sb.size() == 0) return;
            tick();
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    // Scoreboard monitor: pops on each handshake, and checks that a stalled
    // word is still presented unchanged on the following cycle.
    bit          stall = 1'b0;
    logic [31:0] pd;
    logic        pl;
    always @(negedge clk) begin
        exp_t e;
        if (!nrst || clr) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", out_data, 0);
                    total++; bad++;
                    $display("FAIL sb_underflow: got word %0h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", out_data, e.d);
                    chk("word_last", out_last, e.last);
                end
            end
            stall = out_valid && !out_ready;
            pd    = out_data;
            pl    = out_last;
        end
    end

    // Backpressure pattern 1,0,0,1 repeating while pat_mode is set.
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #2;
            if (pat_mode) begin
                out_ready = (c % 4 == 0) || (c % 4 == 3);
                c++;
            end
        end
    end

    initial begin
        int n;
        vecs[0].blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        vecs[0].w   = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        vecs[1].blk = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        vecs[1].w   = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
        vecs[2].blk = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;
        vecs[2].w   = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};

        nrst = 1'b0; clr = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0;
        tick(); tick();
        nrst = 1'b1;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", count, 0);

        // Table vectors, one block at a time with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_vec(i, 1);
            chk("lat_valid", out_valid, 1);
            chk("lat_word0", out_data, vecs[i].w[0]);
            chk("lat_count", count, 1);
            wait_idle("single");
            chk("single_count", count, 0);
            chk("single_valid", out_valid, 0);
        end

        // Backpressure 1,0,0,1,...
        out_ready = 1'b0;
        pat_mode  = 1'b1;
        send_vec(1, 1);
        wait_idle("bp");
        pat_mode  = 1'b0;
        tick();
        chk("bp_count", count, 0);

        // Fill and overflow.
        out_ready = 1'b0;
        send_vec(0, 1);
        chk("fill1_count", count, 1);
        chk("fill1_full", full, 0);
        send_vec(1, 1);
        chk("fill2_full", full, 1);
        chk("fill2_count", count, 2);
        chk("fill2_ovf", overflow, 0);
        send_vec(2, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 2);
        out_ready = 1'b1;
        wait_idle("ovf_drain");
        chk("ovf_sticky", overflow, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Done coincides with the final-word handshake of a full buffer.
        out_ready = 1'b0;
        send_vec(0, 1);
        send_vec(1, 1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("simul_last", out_last, 1);
        chk("simul_full", full, 1);
        send_vec(2, 1);
        chk("simul_count", count, 2);
        chk("simul_ovf", overflow, 0);
        wait_idle("simul");

        // Wrap-around with back-to-back pairs; no bubble between blocks.
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            send_rep(32'(2 * p + 1), 1);
            send_rep(32'(2 * p + 2), 1);
            n = 0;
            while (out_valid && n < 50) begin
                n++;
                tick();
            end
            chk("b2b_cycles", n, 7);
            wait_idle("wrap_pair");
        end
        send_rep(32'd5, 1);
        wait_idle("wrap5");
        chk("wrap_ovf", overflow, 0);

        // Async reset after two words.
        send_vec(0, 1);
        tick(); tick();
        nrst = 1'b0;
        #1;
        chk("amid_valid", out_valid, 0);
        chk("amid_last", out_last, 0);
        chk("amid_data", out_data, 0);
        chk("amid_count", count, 0);
        sb.delete();
        tick();
        nrst = 1'b1;
        tick();

        // clr after two words, with overflow set and a done in the clr cycle.
        out_ready = 1'b0;
        send_vec(0, 1);
        send_vec(1, 1);
        send_vec(2, 0);
        chk("pre_clr_ovf", overflow, 1);
        out_ready = 1'b1;
        tick(); tick();
        clr = 1'b1; done = 1'b1; result = vecs[2].blk; out_ready = 1'b0;
        sb.delete();
        tick();
        clr = 1'b0; done = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);
        tick();
        chk("clr_done_dropped", out_valid, 0);
        out_ready = 1'b1;
        send_vec(1, 1);
        wait_idle("post_clr");
        chk("post_clr_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_out_buf.md
# cipher_out_buf

Downstream stage of the cipher controller. Captures the 128-bit core result on the controller's `done` pulse into a small block FIFO and streams each block out as 32-bit words over a valid/ready interface, most-significant word first. Provides `full` backpressure so upstream logic can hold off `start`, and a sticky `overflow` flag for any result lost when the buffer had no room.

## Interface
- BLOCK_W, 128, result block width; must be an integer multiple of WORD_W
- WORD_W, 32, output word width
- DEPTH, 2, block slots; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear: empties buffer, clears overflow; priority over all other inputs
- done  in  1  one-cycle pulse from controller; `result` valid in the same cycle
- result  in  BLOCK_W  cipher core output block
- out_data  out  WORD_W  current output word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_last  out  1  current word is the final word of its block
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a done arrived with no free slot
- count  out  $clog2(DEPTH+1)  blocks held, including one partially sent

## Operation
- NWORDS = BLOCK_W/WORD_W. Word i of a block = result[BLOCK_W-1-i*WORD_W -: WORD_W]; word 0 first.
- Storage: DEPTH×BLOCK_W array, wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap naturally, word index widx 0..NWORDS-1.
- States: IDLE (count==0, out_valid=0), SEND (count>0, out_valid=1).
- IDLE→SEND: on the edge capturing a done.
- SEND: each transfer increments widx. A transfer at widx==NWORDS-1 pops the block: rd_ptr++, widx=0. The FSM stays in SEND if blocks remain, else goes to IDLE.
- Capture rule: done is accepted if count<DEPTH, or if this cycle pops the last word of a block. The simultaneous pop frees the slot, so a full buffer accepts done at the final-word handshake.
  - Accepted: write result at wr_ptr, wr_ptr++.
  - Otherwise: drop the block and set overflow; count, pointers and stored data are unchanged.
- count: +1 on accept only, −1 on pop only, unchanged when both occur.
- out_last = out_valid && widx==NWORDS-1.
- out_data = selected word when out_valid, else 0.
- While out_valid && !out_ready: out_data, out_last and widx hold stable.
- Reset and clr: count=0, pointers=0, widx=0, IDLE, overflow=0. Stored data need not be cleared.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, full=0, overflow=0, count=0.
- Latency: done at edge k → out_valid=1 with word 0 after edge k (first cycle after capture).
- Throughput: one word per cycle with out_ready held high. Back-to-back blocks have no bubble between word NWORDS-1 of one block and word 0 of the next.
- full, count and overflow are registered and update on the edge after the causing event.
- Reset mid-block: the partially sent block is discarded, and out_valid falls asynchronously with nrst.
- clr and done in the same cycle: clr wins and the block is not captured.

## Structure
- Shared package `aes_pkg` holds:
  - BLOCK_W, WORD_W and NWORDS constants
  - the out-buffer state enum {IDLE, SEND}
- The optional sub-module `cipher_blk_fifo` holds the storage array and pointers only, with write, pop and read-block ports. The serializer FSM and word mux stay in `cipher_out_buf`.

## Test plan
- Single block: done with result=128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 → words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles; out_last on the 4th; then out_valid=0 and count=0.
- Backpressure: out_ready toggled 1,0,0,1,… → each word held stable while stalled, no word skipped or repeated; the block completes after 4 handshakes.
- Fill and overflow: 3 done pulses with out_ready=0 and DEPTH=2 → full=1 after the 2nd; the 3rd sets overflow=1 and count stays 2. Releasing out_ready streams the first two blocks intact.
- Simultaneous pop and done: buffer full, done coincides with the final-word handshake → block accepted, overflow stays 0, count stays 2.
- Wrap-around: 5 blocks (values 1..5 replicated per word) sent with interleaved draining → output order 1..5, pointers wrap with no corruption.
- Reset/clr mid-block: nrst low after 2 words → all outputs reach reset values immediately. Repeat with clr → out_valid=0 and overflow=0 next cycle; a following done streams normally.
